sdram_device_responder: RTL and testbench
=========================================

# sdram_device_responder

Synthesizable SDRAM device-side responder: decodes the command pins driven by `sdram_controller` (CS/RAS/CAS/WE, BA, A, DQM), tracks per-bank open rows, stores data in a small on-chip array and returns read data with programmed CAS latency and burst length. It sits in the user project as a drop-in on the controller's SDRAM pin bus, replacing the behavioural device model for synthesis and gate-level runs, and flags protocol violations to firmware via `err`.

## Interface
- `DATA_W`, 32: DQ width.
- `ROW_IDX_W`, 3: row bits used for storage indexing (`a[ROW_IDX_W-1:0]` at ACTIVE).
- `COL_IDX_W`, 5: column bits used for storage indexing.
- Storage depth = 2^(2+ROW_IDX_W+COL_IDX_W) words (1024 by default).

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cke` in 1: clock enable; low freezes all state (command treated as no-op, bursts and read pipeline hold).
- `cs_n`, `ras_n`, `cas_n`, `we_n` in 1 each: command pins.
- `ba` in 2: bank address.
- `a` in 13: row (ACTIVE), column `a[8:0]` (READ/WRITE), `a[10]` all-banks (PRECHARGE), mode (LOAD MODE).
- `dqm` in 4: byte mask, 1 = masked.
- `dqi` in DATA_W: write data from controller.
- `dqo` out DATA_W: read data to controller.
- `dqo_valid` out 1: `dqo` holds a read beat this cycle.
- `err` out 1: one-cycle pulse on protocol violation.

## Operation
- Command = {cs_n,ras_n,cas_n,we_n}: 1xxx DESELECT, 0111 NOP, 0011 ACTIVE, 0101 READ, 0100 WRITE, 0010 PRECHARGE, 0001 REFRESH, 0000 LOAD MODE, 0110 BURST TERMINATE.
- Per bank: `open` flag + stored row index. ACTIVE on open bank: `err`, row overwritten, bank stays open.
- READ/WRITE to closed bank: `err`, command ignored, active burst unaffected.
- Storage index = {ba, row_idx, col[COL_IDX_W-1:0]}.
- Mode register: `a[6:4]` CL (2 or 3 legal), `a[2:0]` BL code 0/1/2/3 = 1/2/4/8. Illegal field: `err`, whole write rejected. LOAD MODE with any bank open: `err`, rejected.
- WRITE: beat 0 data is `dqi` in the command cycle; remaining beats on consecutive cycles. Byte i written only when `dqm[i]`=0 in that beat's cycle.
- READ: beat 0 appears CL cycles after the command; beats consecutive. `dqm` sampled at each beat's issue cycle; masked bytes output as 0.
- Column sequence: sequential, wrapping inside the BL-aligned block (BL=4, start col 6 -> 6,7,4,5).
- New READ/WRITE during a burst truncates the old burst at that cycle; beats already in the read pipeline are still delivered.
- BURST TERMINATE / PRECHARGE of the burst's bank stop further beat issue that cycle. PRECHARGE `a[10]`=1 closes all banks.
- REFRESH with any bank open: `err`, ignored; otherwise no-op.
- Same-cycle write and read of one address: write completes first; a READ in the following cycle returns new data.

## Timing
- Reset values: all banks closed, CL=3, BL=1, no burst, read pipeline flushed, `dqo`=0, `dqo_valid`=0, `err`=0. Storage not cleared.
- Read latency: command in cycle n -> beat 0 on `dqo` in cycle n+CL, beat k in n+CL+k (with `cke` high throughout).
- `dqo`, `dqo_valid`, `err` registered; `err` asserted cycle after the offending command.
- `dqo` returns to 0 whenever `dqo_valid`=0.
- `cke` low in cycle m: nothing sampled or advanced in m; outputs hold.
- `rst` mid-burst: burst and pipeline discarded next cycle, no further `dqo_valid`.

## Structure
- Package `sdram_pkg`: command encoding constants, mode-field bit positions, CL/BL encodings, beat-count function from BL code.
- Sub-module `sdram_rd_pipe`: 3-deep data/valid shift register with CL-selected tap and `cke` hold; shared later by the controller's read-capture path.
- Storage as one synchronous-read array with per-byte write enables.

## Test plan
- Reset, LOAD MODE CL=2 BL=4, ACTIVE b1 row 2, WRITE col 6 data 0x11..0x44 -> READ col 6 returns 0x11,0x22,0x33,0x44 at cycles n+2..n+5 in wrap order cols 6,7,4,5.
- WRITE 0xAABBCCDD with dqm=0b0101 over 0xFFFFFFFF, READ -> 0xAAFFCCFF; READ with dqm=0b1000 -> 0x00FFCCFF.
- READ to closed bank 3 -> `err` pulse, no `dqo_valid`; ACTIVE twice on bank 0 -> `err`.
- BL=8 READ interrupted by READ after 2 beats (CL=3) -> 2 beats of first, then 8 of second, no gap.
- LOAD MODE CL=5 -> `err`, subsequent READ still uses CL=3; `cke` low 2 cycles mid-burst -> output held, burst resumes with no lost beats.
- `rst` during BL=8 read -> `dqo_valid`=0 from next cycle, all banks closed (READ without ACTIVE gives `err`).

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, mode-register fields and burst helpers.
// Used by the device responder and the controller's read-capture path.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n} with cs_n low; DESELECT is decoded to CmdNop.
    typedef enum logic [3:0] {
        CmdLoadMode  = 4'b0000,
        CmdRefresh   = 4'b0001,
        CmdPrecharge = 4'b0010,
        CmdActive    = 4'b0011,
        CmdWrite     = 4'b0100,
        CmdRead      = 4'b0101,
        CmdBurstTerm = 4'b0110,
        CmdNop       = 4'b0111
    } cmd_e;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite
    } burst_st_e;

    localparam int unsigned ModeClLsb   = 4;
    localparam int unsigned ModeBlLsb   = 0;
    localparam int unsigned AllBanksBit = 10;

    localparam logic [2:0] ClMin     = 3'd2;
    localparam logic [2:0] ClMax     = 3'd3;
    localparam logic [2:0] ClReset   = 3'd3;
    localparam logic [2:0] BlCode1   = 3'd0;
    localparam logic [2:0] BlCodeMax = 3'd3;

    function automatic logic [3:0] bl_beats(input logic [2:0] code);
        return 4'd1 << code;
    endfunction

endpackage

// File: rtl/sdram_device_responder_if.sv
// SDRAM pin bus between controller (master) and device responder (slave).
interface sdram_device_responder_if #(
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned NB = DATA_W / 8;

    logic              cke;
    logic              cs_n;
    logic              ras_n;
    logic              cas_n;
    logic              we_n;
    logic [1:0]        ba;
    logic [12:0]       a;
    logic [NB-1:0]     dqm;
    logic [DATA_W-1:0] dqi;
    logic [DATA_W-1:0] dqo;
    logic              dqo_valid;
    logic              err;

    modport master (
        output cke, cs_n, ras_n, cas_n, we_n, ba, a, dqm, dqi,
        input  dqo, dqo_valid, err
    );

    modport slave (
        input  cke, cs_n, ras_n, cas_n, we_n, ba, a, dqm, dqi,
        output dqo, dqo_valid, err
    );

endinterface

// File: rtl/sdram_rd_pipe.sv
// Read-data delay line: input arrives one cycle after the READ issue, output register
// is loaded from a CL-selected tap so beat 0 lands CL cycles after the command.
module sdram_rd_pipe #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cke,
    input  logic [2:0]        cl,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [1:0]        st_v_q;
    logic [DATA_W-1:0] st_d_q [2];
    logic              tap_v;
    logic [DATA_W-1:0] tap_d;

    always_comb begin
        tap_v = st_v_q[1];
        tap_d = st_d_q[1];
        case (cl)
            3'd2: begin
                tap_v = in_valid;
                tap_d = in_data;
            end
            3'd3: begin
                tap_v = st_v_q[0];
                tap_d = st_d_q[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_v_q    <= '0;
            st_d_q[0] <= '0;
            st_d_q[1] <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (cke) begin
            st_v_q    <= {st_v_q[0], in_valid};
            st_d_q[0] <= in_data;
            st_d_q[1] <= st_d_q[0];
            out_valid <= tap_v;
            out_data  <= tap_v ? tap_d : '0;
        end
    end

endmodule

// File: rtl/sdram_device_responder.sv
// Synthesizable SDRAM device model: decodes controller commands, tracks open rows,
// stores data in an on-chip array and returns bursts with programmed CL/BL.
module sdram_device_responder
    import sdram_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ROW_IDX_W = 3,
    parameter int unsigned COL_IDX_W = 5
) (
    input logic               clk,
    input logic               rst,
    sdram_device_responder_if.slave bus
);

    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned ADDR_W = 2 + ROW_IDX_W + COL_IDX_W;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    cmd_e cmd;

    logic [3:0]           bank_open_q, bank_open_d;
    logic [ROW_IDX_W-1:0] bank_row_q [4];
    logic [ROW_IDX_W-1:0] bank_row_d [4];
    logic [2:0]           cl_q, cl_d, bl_q, bl_d;

    burst_st_e            state_q, state_d;
    logic [1:0]           bank_q, bank_d;
    logic [ROW_IDX_W-1:0] row_q, row_d;
    logic [COL_IDX_W-1:0] col_q, col_d;
    logic [2:0]           beat_q, beat_d, mask_q, mask_d;
    logic                 err_q, err_d;

    logic                 start, stop, cl_legal, bl_legal;
    logic [3:0]           new_beats;
    logic [2:0]           new_mask;
    logic                 iss_valid, iss_write;
    logic [1:0]           iss_bank;
    logic [ROW_IDX_W-1:0] iss_row;
    logic [COL_IDX_W-1:0] iss_start, iss_col, iss_mask_c, iss_beat_c;
    logic [2:0]           iss_beat, iss_mask;
    logic [ADDR_W-1:0]    iss_addr;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [DATA_W-1:0]    rdata_q, rdata_m;
    logic                 rd_v_q;
    logic [NB-1:0]        rd_mask_q;
    logic                 unused_a;

    assign unused_a = ^bus.a;

    always_comb begin
        if (bus.cs_n) cmd = CmdNop;
        else          cmd = cmd_e'({bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n});
    end

    assign cl_legal  = (bus.a[ModeClLsb +: 3] == ClMin) || (bus.a[ModeClLsb +: 3] == ClMax);
    assign bl_legal  = bus.a[ModeBlLsb +: 3] <= BlCodeMax;
    assign new_beats = bl_beats(bl_q);
    assign new_mask  = 3'(new_beats - 4'd1);

    always_comb begin
        bank_open_d = bank_open_q;
        bank_row_d  = bank_row_q;
        cl_d        = cl_q;
        bl_d        = bl_q;
        state_d     = state_q;
        bank_d      = bank_q;
        row_d       = row_q;
        col_d       = col_q;
        beat_d      = beat_q;
        mask_d      = mask_q;
        err_d       = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        iss_valid   = 1'b0;
        iss_write   = 1'b0;
        iss_bank    = bank_q;
        iss_row     = row_q;
        iss_start   = col_q;
        iss_beat    = beat_q;
        iss_mask    = mask_q;

        case (cmd)
            CmdActive: begin
                err_d                 = bank_open_q[bus.ba];
                bank_open_d[bus.ba]   = 1'b1;
                bank_row_d[bus.ba]    = bus.a[ROW_IDX_W-1:0];
            end
            CmdRead, CmdWrite: begin
                if (bank_open_q[bus.ba]) start = 1'b1;
                else                     err_d = 1'b1;
            end
            CmdPrecharge: begin
                if (bus.a[AllBanksBit]) begin
                    bank_open_d = '0;
                    stop        = 1'b1;
                end else begin
                    bank_open_d[bus.ba] = 1'b0;
                    stop                = (bus.ba == bank_q);
                end
            end
            CmdRefresh: err_d = |bank_open_q;
            CmdLoadMode: begin
                if ((|bank_open_q) || !cl_legal || !bl_legal) begin
                    err_d = 1'b1;
                end else begin
                    cl_d = bus.a[ModeClLsb +: 3];
                    bl_d = bus.a[ModeBlLsb +: 3];
                end
            end
            CmdBurstTerm: stop = 1'b1;
            default: ;
        endcase

        // A new READ/WRITE always wins over the running burst, truncating it.
        if (start) begin
            iss_valid = 1'b1;
            iss_write = (cmd == CmdWrite);
            iss_bank  = bus.ba;
            iss_row   = bank_row_q[bus.ba];
            iss_start = bus.a[COL_IDX_W-1:0];
            iss_beat  = '0;
            iss_mask  = new_mask;
            bank_d    = bus.ba;
            row_d     = bank_row_q[bus.ba];
            col_d     = bus.a[COL_IDX_W-1:0];
            beat_d    = 3'd1;
            mask_d    = new_mask;
            if (new_mask == 3'd0) state_d = StIdle;
            else                  state_d = iss_write ? StWrite : StRead;
        end else if (state_q != StIdle && !stop) begin
            iss_valid = 1'b1;
            iss_write = (state_q == StWrite);
            beat_d    = beat_q + 3'd1;
            if (beat_q == mask_q) state_d = StIdle;
        end else if (stop) begin
            state_d = StIdle;
        end

        // Wrap inside the BL-aligned column block.
        iss_mask_c = COL_IDX_W'(iss_mask);
        iss_beat_c = COL_IDX_W'(iss_beat);
        iss_col    = (iss_start & ~iss_mask_c) | ((iss_start + iss_beat_c) & iss_mask_c);
        iss_addr   = {iss_bank, iss_row, iss_col};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_open_q <= '0;
            cl_q        <= ClReset;
            bl_q        <= BlCode1;
            state_q     <= StIdle;
            bank_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            beat_q      <= '0;
            mask_q      <= '0;
            err_q       <= 1'b0;
            rd_v_q      <= 1'b0;
            rd_mask_q   <= '0;
        end else if (bus.cke) begin
            bank_open_q <= bank_open_d;
            cl_q        <= cl_d;
            bl_q        <= bl_d;
            state_q     <= state_d;
            bank_q      <= bank_d;
            row_q       <= row_d;
            col_q       <= col_d;
            beat_q      <= beat_d;
            mask_q      <= mask_d;
            err_q       <= err_d;
            rd_v_q      <= iss_valid && !iss_write;
            rd_mask_q   <= bus.dqm;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.cke) begin
            bank_row_q <= bank_row_d;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.cke) begin
            for (int i = 0; i < NB; i++) begin
                if (!rst && iss_valid && iss_write && !bus.dqm[i]) begin
                    mem[iss_addr][8*i +: 8] <= bus.dqi[8*i +: 8];
                end
            end
            rdata_q <= mem[iss_addr];
        end
    end

    always_comb begin
        rdata_m = rdata_q;
        for (int i = 0; i < NB; i++) begin
            if (rd_mask_q[i]) rdata_m[8*i +: 8] = 8'h00;
        end
    end

    sdram_rd_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .cke       (bus.cke),
        .cl        (cl_q),
        .in_valid  (rd_v_q),
        .in_data   (rdata_m),
        .out_valid (bus.dqo_valid),
        .out_data  (bus.dqo)
    );

    assign bus.err = err_q;

endmodule

// File: tb/tb_sdram_device_responder.sv
// Directed bench for sdram_device_responder: a vector table for the basic flows plus
// hand-written sequences for burst truncation, cke stalls and mid-burst reset.
module tb_sdram_device_responder;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] LMR = 4'b0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    sdram_device_responder_if #(.DATA_W(32)) bus ();

    sdram_device_responder #(
        .DATA_W    (32),
        .ROW_IDX_W (3),
        .COL_IDX_W (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] a;
        logic [3:0]  dqm;
        logic [31:0] dqi;
        logic        ev;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [3:0] c, input logic [1:0] b, input logic [12:0] ad,
                                input logic [3:0] m, input logic [31:0] d, input logic ev,
                                input logic [31:0] ed, input logic ee);
        vec_t v;
        v.cmd = c; v.ba = b; v.a = ad; v.dqm = m; v.dqi = d;
        v.ev = ev; v.ed = ed; v.ee = ee;
        return v;
    endfunction

    task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [12:0] ad,
                         input logic [3:0] m, input logic [31:0] d, input logic ke);
        {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} = c;
        bus.ba  = b;
        bus.a   = ad;
        bus.dqm = m;
        bus.dqi = d;
        bus.cke = ke;
    endtask

    // Advance one clock and compare the outputs of the following cycle.
    task automatic step(input string name, input logic ev, input logic [31:0] ed, input logic ee);
        @(posedge clk);
        #1;
        total++;
        if (bus.dqo_valid !== ev || bus.dqo !== ed || bus.err !== ee) begin
            bad++;
            $display("FAIL %s: got valid=%0b dqo=%h err=%0b, want valid=%0b dqo=%h err=%0b",
                     name, bus.dqo_valid, bus.dqo, bus.err, ev, ed, ee);
        end
    endtask

    initial begin
        int act;
        int k;

        // CL=2 BL=4 write/read with wrap, byte masks, error cases.
        vq.push_back(mk(LMR, 0, 13'h022, 0, 0, 0, 0, 0));
        vq.push_back(mk(ACT, 1, 13'd2, 0, 0, 0, 0, 0));
        vq.push_back(mk(WR, 1, 13'd6, 0, 32'h11, 0, 0, 0));
        vq.push_back(mk(NOP, 0, 0, 0, 32'h22, 0, 0, 0));
        vq.push_back(mk(NOP, 0, 0, 0, 32'h33, 0, 0, 0));
        vq.push_back(mk(NOP, 0, 0, 0, 32'h44, 0, 0, 0));
        vq.push_back(mk(RD, 1, 13'd6, 0, 0, 0, 0, 0));
        vq.push_back(mk(NOP, 0, 0, 0, 0, 1, 32'h11, 0));
        vq.push_back(mk(NOP, 0, 0, 0, 0, 1, 32'h22, 0));
        vq.push_back(mk(NOP, 0, 0, 0, 0, 1, 32'h33, 0));
        vq.push_back(mk(NOP, 0, 0, 0, 0, 1, 32'h44, 0));
        vq.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(RD, 1, 13'd4, 0, 0, 0, 0, 0));
        vq.push_back(mk(NOP, 0, 0, 0, 0, 1, 32'h33, 0));
        vq.push_back(mk(NOP, 0, 0, 0, 0, 1, 32'h44, 0));
        vq.push_back(mk(NOP, 0, 0, 0, 0, 1, 32'h11, 0));
        vq.push_back(mk(NOP, 0, 0, 0, 0, 1, 32'h22, 0));
        vq.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(PRE, 0, 13'h400, 0, 0, 0, 0, 0));
        vq.push_back(mk(LMR, 0, 13'h020, 0, 0, 0, 0, 0));
        vq.push_back(mk(ACT, 1, 13'd2, 0, 0, 0, 0, 0));
        vq.push_back(mk(WR, 1, 13'd0, 4'b0000, 32'hFFFF_FFFF, 0, 0, 0));
        vq.push_back(mk(WR, 1, 13'd0, 4'b0101, 32'hAABB_CCDD, 0, 0, 0));
        vq.push_back(mk(RD, 1, 13'd0, 4'b0000, 0, 0, 0, 0));
        vq.push_back(mk(NOP, 0, 0, 0, 0, 1, 32'hAAFF_CCFF, 0));
        vq.push_back(mk(RD, 1, 13'd0, 4'b1000, 0, 0, 0, 0));
        vq.push_back(mk(NOP, 0, 0, 0, 0, 1, 32'h00FF_CCFF, 0));
        vq.push_back(mk(WR, 1, 13'd1, 0, 32'h1234_5678, 0, 0, 0));
        vq.push_back(mk(RD, 1, 13'd1, 0, 0, 0, 0, 0));
        vq.push_back(mk(NOP, 0, 0, 0, 0, 1, 32'h1234_5678, 0));
        vq.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(RD, 3, 13'd0, 0, 0, 0, 0, 1));
        vq.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(ACT, 0, 13'd1, 0, 0, 0, 0, 0));
        vq.push_back(mk(ACT, 0, 13'd3, 0, 0, 0, 0, 1));
        vq.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(WR, 2, 13'd0, 0, 32'hDEAD_BEEF, 0, 0, 1));
        vq.push_back(mk(REF, 0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(LMR, 0, 13'h022, 0, 0, 0, 0, 1));
        vq.push_back(mk(NOP, 0, 0, 0, 0, 0, 0, 0));

        drive(NOP, 0, 0, 0, 0, 1);
        rst = 1'b1;
        step("reset0", 0, 0, 0);
        step("reset1", 0, 0, 0);
        rst = 1'b0;

        foreach (vq[i]) begin
            drive(vq[i].cmd, vq[i].ba, vq[i].a, vq[i].dqm, vq[i].dqi, 1'b1);
            step($sformatf("vec%0d", i), vq[i].ev, vq[i].ed, vq[i].ee);
        end

        // CL=3 BL=8: fill cols 0..15 of bank 2, then interrupt one read with another.
        drive(PRE, 0, 13'h400, 0, 0, 1); step("a_pre", 0, 0, 0);
        drive(LMR, 0, 13'h033, 0, 0, 1); step("a_lmr", 0, 0, 0);
        drive(ACT, 2, 13'd5, 0, 0, 1);   step("a_act", 0, 0, 0);
        for (int w = 0; w < 16; w++) begin
            if (w % 8 == 0) drive(WR, 2, 13'(w), 0, 32'h100 * (w / 8 + 1), 1);
            else            drive(NOP, 0, 0, 0, 32'h100 * (w / 8 + 1) + 32'(w % 8), 1);
            step($sformatf("a_wr%0d", w), 0, 0, 0);
        end
        for (int t = 0; t < 14; t++) begin
            if (t == 0)      drive(RD, 2, 13'd0, 0, 0, 1);
            else if (t == 2) drive(RD, 2, 13'd8, 0, 0, 1);
            else             drive(NOP, 0, 0, 0, 0, 1);
            k = t + 1;
            if (k == 3 || k == 4)
                step($sformatf("a_rd%0d", t), 1, 32'h100 + 32'(k - 3), 0);
            else if (k >= 5 && k <= 12)
                step($sformatf("a_rd%0d", t), 1, 32'h200 + 32'(k - 5), 0);
            else
                step($sformatf("a_rd%0d", t), 0, 0, 0);
        end

        // Illegal CL is rejected; BL=8 CL=3 read with a two-cycle cke stall.
        drive(PRE, 0, 13'h400, 0, 0, 1); step("b_pre", 0, 0, 0);
        drive(LMR, 0, 13'h052, 0, 0, 1); step("b_lmr", 0, 0, 1);
        drive(ACT, 2, 13'd5, 0, 0, 1);   step("b_act", 0, 0, 0);
        act = 0;
        for (int t = 0; t < 15; t++) begin
            logic ke;
            ke = !(t == 3 || t == 4);
            if (t == 0) drive(RD, 2, 13'd0, 0, 0, ke);
            else        drive(NOP, 0, 0, 0, 0, ke);
            if (ke) act++;
            k = act - 3;
            if (k >= 0 && k < 8) step($sformatf("b_rd%0d", t), 1, 32'h100 + 32'(k), 0);
            else                 step($sformatf("b_rd%0d", t), 0, 0, 0);
        end

        // Reset in the middle of a BL=8 read.
        for (int t = 0; t < 10; t++) begin
            if (t == 0) drive(RD, 2, 13'd0, 0, 0, 1);
            else        drive(NOP, 0, 0, 0, 0, 1);
            rst = (t == 4);
            k = t + 1;
            if (k == 3 || k == 4) step($sformatf("c_rd%0d", t), 1, 32'h100 + 32'(k - 3), 0);
            else                  step($sformatf("c_rd%0d", t), 0, 0, 0);
        end
        rst = 1'b0;
        drive(RD, 2, 13'd0, 0, 0, 1); step("c_closed", 0, 0, 1);
        drive(NOP, 0, 0, 0, 0, 1);    step("c_nop0", 0, 0, 0);
        drive(NOP, 0, 0, 0, 0, 1);    step("c_nop1", 0, 0, 0);
        drive(NOP, 0, 0, 0, 0, 1);    step("c_nop2", 0, 0, 0);

        // Reset mode is CL=3 BL=1.
        drive(ACT, 0, 13'd0, 0, 0, 1);            step("d_act", 0, 0, 0);
        drive(WR, 0, 13'd3, 0, 32'hCAFE_F00D, 1); step("d_wr", 0, 0, 0);
        drive(RD, 0, 13'd3, 0, 0, 1);             step("d_rd0", 0, 0, 0);
        drive(NOP, 0, 0, 0, 0, 1);                step("d_rd1", 0, 0, 0);
        drive(NOP, 0, 0, 0, 0, 1);                step("d_rd2", 1, 32'hCAFE_F00D, 0);
        drive(NOP, 0, 0, 0, 0, 1);                step("d_rd3", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
